// File: rtl/seis_event_gen_if.sv
// Configuration write bus for seis_event_gen: single-cycle strobe, no handshake back.
// cfg_we qualifies cfg_ch/cfg_mode/cfg_val on the rising edge where it is high.
interface seis_event_gen_if #(
  parameter int N_BITS = 5,
  parameter int CH_W   = 2
);
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [N_BITS-1:0] cfg_val;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_val);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_val);
endinterface

// File: rtl/seis_event_gen.sv
// Free-running modulo counter driving N_CH programmable control channels
// (OFF / MATCH / EVERY / WINDOW), each output registered one cycle after its hit.
module seis_event_gen #(
  parameter int N_BITS = 5,
  parameter int N_CH   = 3,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              clear,
  input  logic [N_BITS-1:0] terminal,
  seis_event_gen_if.slave   cfg,
  output logic [N_BITS-1:0] o_count,
  output logic              o_wrap,
  output logic [N_CH-1:0]   o_control
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_MATCH  = 2'b01,
    MODE_EVERY  = 2'b10,
    MODE_WINDOW = 2'b11
  } mode_e;

  localparam logic [CH_W:0] LP_NCH = N_CH[CH_W:0];

  logic [N_BITS-1:0] r_count;
  logic              r_wrap;
  logic [N_CH-1:0]   r_control;
  logic [N_CH-1:0]   w_hit;
  logic              w_at_term;
  logic              w_cfg_ok;

  assign w_at_term = (r_count >= terminal);
  // Writes to channels beyond N_CH are dropped silently.
  assign w_cfg_ok  = cfg.cfg_we && ({1'b0, cfg.cfg_ch} < LP_NCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_control <= '0;
    end else if (clear) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_control <= '0;
    end else if (clk_enable) begin
      r_count   <= w_at_term ? '0 : r_count + 1'b1;
      r_wrap    <= w_at_term;
      r_control <= w_hit;
    end else begin
      r_wrap    <= 1'b0;
      r_control <= '0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mode_e             r_mode;
    logic [N_BITS-1:0] r_val;
    logic [N_BITS-1:0] r_ph;
    logic [N_BITS-1:0] w_lim;
    logic [N_BITS-1:0] w_ph_nxt;
    logic              w_wr;

    // val 0 and 1 both mean "every cycle", so the phase limit saturates at 0.
    assign w_lim    = (r_val == '0) ? '0 : r_val - 1'b1;
    assign w_ph_nxt = (r_ph >= w_lim) ? '0 : r_ph + 1'b1;
    assign w_wr     = w_cfg_ok && (cfg.cfg_ch == CH_W'(g));

    assign w_hit[g] = (r_mode == MODE_MATCH)  ? (r_count == r_val) :
                      (r_mode == MODE_WINDOW) ? (r_count >= r_val) :
                      (r_mode == MODE_EVERY)  ? (r_ph == '0)       : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_mode <= MODE_OFF;
        r_val  <= '0;
        r_ph   <= '0;
      end else begin
        if (clear) begin
          r_ph <= '0;
        end else if (clk_enable) begin
          r_ph <= w_ph_nxt;
        end
        // A write restarts the phase; the hit for this edge already used the old setting.
        if (w_wr) begin
          r_mode <= mode_e'(cfg.cfg_mode);
          r_val  <= cfg.cfg_val;
          r_ph   <= '0;
        end
      end
    end
  end

  assign o_count   = r_count;
  assign o_wrap    = r_wrap;
  assign o_control = r_control;

endmodule
